alu_instr_sequencer: RTL and testbench

Parametrised control sequencer that drives the datapath through the full fetch/execute sequence for register-register ALU instructions. It generates, cycle by cycle, the bus-drive, register-load, memory and ALU-opcode strobes that the phase-1 benches sequence by hand. It sits between the instruction source (start/done handshake) and the datapath control inputs. It adds a two-cycle HI/LO writeback for multiply/divide and an optional memory-ready wait.

---
 rtl/alu_instr_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Moore control sequencer for register-register ALU instructions. Walks the
//   datapath through fetch (T0..T2), operand read (T3..T4) and writeback
//   (T5, or T5M/T6M for multiply/divide with HI/LO results), raising the
//   bus-drive, load, memory and ALU-opcode strobes for each state.
//
//   Optional feature macro: SEQ_MEM_WAIT_EN
//     defined   -> T1 holds (in a wait state) until mem_rdy=1
//     undefined -> T1 lasts one cycle, mem_rdy is ignored
//
// Ports
//   clk          clock
//   clr          synchronous active-high reset
//   start        begin one instruction (sampled only in IDLE)
//   mem_rdy      memory read complete (used only with SEQ_MEM_WAIT_EN)
//   ir_q         IR contents, valid from T3 onward
//   busy         high in every state except IDLE
//   done         one-cycle pulse in the final writeback state
//   PCout..LOin  single-bit datapath strobes
//   reg_out      one-hot register bus-drive select
//   reg_in       one-hot register load select
//   ALU_Control  ALU opcode (holds its last driven value)
module alu_instr_sequencer #(
  parameter int REG_AW = 4,
  parameter int OP_W   = 5,
  parameter int IR_W   = 32,
  parameter int INC_OP = 12,
  parameter int MUL_OP = 15,
  parameter int DIV_OP = 16,
  localparam int NUM_REGS = 2**REG_AW
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_rdy,
  input  logic [IR_W-1:0]     ir_q,
  output logic                busy,
  output logic                done,
  output logic                PCout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OP_W-1:0]     ALU_Control
);

  // Field positions: opcode on top, then Ra, Rb, Rc in consecutive fields.
  localparam int RA_MSB = IR_W - OP_W - 1;
  localparam int RB_MSB = RA_MSB - REG_AW;
  localparam int RC_MSB = RB_MSB - REG_AW;
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

  // T1W is the memory-wait continuation of T1: same Read/MDRin, but the
  // PC update strobes are not repeated.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T5M  = 4'd8,
    S_T6M  = 4'd9
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [OP_W-1:0]      op_r;
  logic [REG_AW-1:0]    ra_r;
  logic [REG_AW-1:0]    rb_r;
  logic [REG_AW-1:0]    rc_r;
  logic [OP_W-1:0]      alu_r;
  logic                 is_muldiv;
  logic                 unused_inputs;

  // Low IR bits beyond the register fields are not part of this format.
  assign unused_inputs = ^{ir_q, mem_rdy};

  assign is_muldiv = (op_r == OP_W'(MUL_OP)) || (op_r == OP_W'(DIV_OP));

  // State register and instruction fields captured on the T2->T3 edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      op_r  <= '0;
      ra_r  <= '0;
      rb_r  <= '0;
      rc_r  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T2) begin
        op_r <= ir_q[IR_W-1 -: OP_W];
        ra_r <= ir_q[RA_MSB -: REG_AW];
        rb_r <= ir_q[RB_MSB -: REG_AW];
        rc_r <= ir_q[RC_MSB -: REG_AW];
      end
    end
  end

  // ALU opcode register: loaded when entering T0 or T4, held otherwise.
  always_ff @(posedge clk) begin
    if (clr) begin
      alu_r <= '0;
    end else if (state_nxt == S_T0) begin
      alu_r <= OP_W'(INC_OP);
    end else if (state_nxt == S_T4) begin
      alu_r <= op_r;
    end else begin
      alu_r <= alu_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_T0;
        else       state_nxt = S_IDLE;
      end
      S_T0: state_nxt = S_T1;
`ifdef SEQ_MEM_WAIT_EN
      S_T1: begin
        if (mem_rdy) state_nxt = S_T2;
        else         state_nxt = S_T1W;
      end
      S_T1W: begin
        if (mem_rdy) state_nxt = S_T2;
        else         state_nxt = S_T1W;
      end
`else
      S_T1: state_nxt = S_T2;
`endif
      S_T2: state_nxt = S_T3;
      S_T3: state_nxt = S_T4;
      S_T4: begin
        if (is_muldiv) state_nxt = S_T5M;
        else           state_nxt = S_T5;
      end
      S_T5:    state_nxt = S_IDLE;
      S_T5M:   state_nxt = S_T6M;
      S_T6M:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    reg_out  = '0;
    reg_in   = '0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        reg_out = ONE_HOT0 << rb_r;
        Yin     = 1'b1;
      end
      S_T4: begin
        reg_out = ONE_HOT0 << rc_r;
        Zin     = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        reg_in  = ONE_HOT0 << ra_r;
        done    = 1'b1;
      end
      S_T5M: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
      end
      S_T6M: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign ALU_Control = alu_r;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        clr, start, mem_rdy;
  logic [31:0] ir_q;
  logic        busy, done, PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  ALU_Control;
  logic [12:0] strb_s;

  alu_instr_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir_q(ir_q),
    .busy(busy), .done(done), .PCout(PCout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .reg_out(reg_out), .reg_in(reg_in), .ALU_Control(ALU_Control)
  );

  always #5 clk = ~clk;

  assign strb_s = {PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin,
                   Yin, Zlowout, Zhighout, HIin, LOin};

  localparam logic [12:0] M_PCOUT = 13'h1000, M_MARIN = 13'h0800, M_ZIN = 13'h0400;
  localparam logic [12:0] M_PCIN = 13'h0200, M_READ = 13'h0100, M_MDRIN = 13'h0080;
  localparam logic [12:0] M_MDROUT = 13'h0040, M_IRIN = 13'h0020, M_YIN = 13'h0010;
  localparam logic [12:0] M_ZLO = 13'h0008, M_ZHI = 13'h0004, M_HIIN = 13'h0002;
  localparam logic [12:0] M_LOIN = 13'h0001;

  localparam logic [31:0] I_PLAIN = 32'h28918000; // op 5, Ra 1, Rb 2, Rc 3
  localparam logic [31:0] I_MUL   = 32'h78918000; // op 15
  localparam logic [31:0] I_DIV   = 32'h80918000; // op 16
  localparam logic [31:0] I_UNDEF = 32'hF8918000; // op 31
  localparam logic [31:0] I_REGS  = 32'h2F838000; // op 5, Ra 15, Rb 0, Rc 7

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model: per-cycle expected output table
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        t1;
    logic [12:0] strb;
    logic [15:0] ro;
    logic [15:0] ri;
    logic        av;
    logic [4:0]  alu;
  } vec_t;

  vec_t       q[$];
  vec_t       cur = '0;
  logic [4:0] alu_m = 5'd0;

  function automatic vec_t mkv(logic [12:0] s, logic [15:0] ro, logic [15:0] ri,
                               logic av, logic [4:0] alu, logic dn, logic t1);
    vec_t v;
    v.busy = 1'b1; v.done = dn; v.t1 = t1; v.strb = s;
    v.ro = ro; v.ri = ri; v.av = av; v.alu = alu;
    return v;
  endfunction

  task automatic build(input logic [31:0] ir);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    q.delete();
    q.push_back(mkv(M_PCOUT | M_MARIN | M_ZIN, 16'd0, 16'd0, 1'b1, 5'd12, 1'b0, 1'b0));
    q.push_back(mkv(M_ZLO | M_PCIN | M_READ | M_MDRIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b0, 1'b1));
    q.push_back(mkv(M_MDROUT | M_IRIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b0, 1'b0));
    q.push_back(mkv(M_YIN, 16'd1 << rb, 16'd0, 1'b0, 5'd0, 1'b0, 1'b0));
    q.push_back(mkv(M_ZIN, 16'd1 << rc, 16'd0, 1'b1, op, 1'b0, 1'b0));
    if (op == 5'd15 || op == 5'd16) begin
      q.push_back(mkv(M_ZLO | M_LOIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b0, 1'b0));
      q.push_back(mkv(M_ZHI | M_HIIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b1, 1'b0));
    end else begin
      q.push_back(mkv(M_ZLO, 16'd0, 16'd1 << ra, 1'b0, 5'd0, 1'b1, 1'b0));
    end
  endtask

  always @(posedge clk) begin
    if (clr) begin
      q.delete(); cur = '0; alu_m = 5'd0;
    end else begin
      if (!cur.busy) begin
        if (start) begin build(ir_q); cur = q.pop_front(); end
      end
`ifdef SEQ_MEM_WAIT_EN
      else if (cur.t1 && !mem_rdy)
        cur = mkv(M_READ | M_MDRIN, 16'd0, 16'd0, 1'b0, 5'd0, 1'b0, 1'b1);
`endif
      else if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
      if (cur.av) alu_m = cur.alu;
    end
  end

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, cur.busy);
      chk("done", done, cur.done);
      chk("strobes", strb_s, cur.strb);
      chk("reg_out", reg_out, cur.ro);
      chk("reg_in", reg_in, cur.ri);
      chk("alu_ctrl", ALU_Control, alu_m);
    end
  end

  // ---------------- directed instruction runner with cycle logs
  logic [4:0]  lg_alu [0:31];
  logic [15:0] lg_ro  [0:31];
  logic [15:0] lg_ri  [0:31];
  logic [12:0] lg_st  [0:31];
  logic        lg_dn  [0:31];
  int n_busy, done_at, n_done, n_pcin, n_read;
  bit ri_any;

  // Cycle 1 is the first cycle after the start edge; mem_rdy is low in
  // cycles 2 .. 1+wait_n; start is re-pulsed in cycles pa and pb.
  task automatic go(input logic [31:0] ir, input int wait_n, input int pa, input int pb);
    bit ended;
    n_busy = 0; done_at = 0; n_done = 0; n_pcin = 0; n_read = 0; ri_any = 0; ended = 0;
    ir_q = ir; start = 1'b1;
    for (int i = 1; i <= 30 && !ended; i++) begin
      @(negedge clk);
      start   = (i == pa) || (i == pb);
      mem_rdy = !(i >= 2 && i < 2 + wait_n);
      lg_alu[i] = ALU_Control; lg_ro[i] = reg_out; lg_ri[i] = reg_in;
      lg_st[i] = strb_s; lg_dn[i] = done;
      if (busy) begin
        n_busy++;
        if (done) begin n_done++; done_at = i; end
        if (PCin) n_pcin++;
        if (Read) n_read++;
        if (reg_in != 16'd0) ri_any = 1'b1;
      end else begin
        ended = 1'b1;
      end
    end
    mem_rdy = 1'b1; start = 1'b0;
    if (!ended) chk("go_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_rdy = 1'b1; ir_q = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu", ALU_Control, 5'd0);
    chk("rst_strobes", strb_s, 13'd0);
    chk("rst_regs", {reg_out, reg_in}, 32'd0);
    clr = 1'b0;

    // Plain op: 6 busy cycles with hand-computed per-state values.
    go(I_PLAIN, 0, 0, 0);
    chk("plain_busy_cycles", n_busy, 6);
    chk("plain_done_at", done_at, 6);
    chk("plain_done_cnt", n_done, 1);
    chk("plain_t0_alu", lg_alu[1], 5'd12);
    chk("plain_t3_regout", lg_ro[3+1], 16'h0004);
    chk("plain_t3_yin", lg_st[4], M_YIN);
    chk("plain_t4_regout", lg_ro[5], 16'h0008);
    chk("plain_t4_alu", lg_alu[5], 5'd5);
    chk("plain_t4_zin", lg_st[5], M_ZIN);
    chk("plain_t5_regin", lg_ri[6], 16'h0002);
    chk("plain_t5_done", lg_dn[6], 1'b1);
    chk("plain_alu_hold", ALU_Control, 5'd5);
    chk("model_alu_hold", alu_m, 5'd5);

    // Multiply: HI/LO writeback, 7 cycles, no register load.
    go(I_MUL, 0, 0, 0);
    chk("mul_busy_cycles", n_busy, 7);
    chk("mul_done_at", done_at, 7);
    chk("mul_t4_alu", lg_alu[5], 5'd15);
    chk("mul_t5m", lg_st[6], M_ZLO | M_LOIN);
    chk("mul_t6m", lg_st[7], M_ZHI | M_HIIN);
    chk("mul_t6m_done", lg_dn[7], 1'b1);
    chk("mul_no_regin", ri_any, 1'b0);

    // Divide and an undefined opcode.
    go(I_DIV, 0, 0, 0);
    chk("div_done_at", done_at, 7);
    go(I_UNDEF, 0, 0, 0);
    chk("undef_done_at", done_at, 6);
    chk("undef_alu", lg_alu[5], 5'd31);

    // Boundary register fields.
    go(I_REGS, 0, 0, 0);
    chk("regs_t3", lg_ro[4], 16'h0001);
    chk("regs_t4", lg_ro[5], 16'h0080);
    chk("regs_t5", lg_ri[6], 16'h8000);

    // Memory wait: mem_rdy low for 3 cycles in T1.
    go(I_PLAIN, 3, 0, 0);
    chk("wait_pcin_cnt", n_pcin, 1);
`ifdef SEQ_MEM_WAIT_EN
    chk("wait_read_cnt", n_read, 4);
    chk("wait_done_at", done_at, 9);
`else
    chk("wait_read_cnt", n_read, 1);
    chk("wait_done_at", done_at, 6);
`endif

    // Start pulses while busy (mid-run and in the done cycle) are ignored.
    go(I_PLAIN, 0, 3, 6);
    chk("pulse_busy_cycles", n_busy, 6);
    repeat (3) begin
      @(negedge clk);
      chk("pulse_no_restart", busy, 1'b0);
    end

    // clr during T3 abandons the instruction.
    ir_q = I_PLAIN; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_pre_t3", strb_s, M_YIN);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 1'b0);
    chk("clr_outputs", {strb_s, ALU_Control}, 18'd0);
    chk("clr_regs", {reg_out, reg_in}, 32'd0);
    go(I_PLAIN, 0, 0, 0);
    chk("clr_restart_cycles", n_busy, 6);

    // start held high: back-to-back with one IDLE cycle in between.
    ir_q = I_PLAIN; start = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      chk("b2b_busy", busy, ((i - 1) % 7) != 6);
      chk("b2b_done", done, ((i - 1) % 7) == 5);
    end
    start = 1'b0;
    for (int i = 0; i < 12 && busy; i++) @(negedge clk);
    chk("b2b_drain", busy, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
